// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART transmit scheduler: bus-fed byte FIFO that strobes the core only when idle
// Raises a level interrupt once the queue has drained and the core is quiet.
module uart_tx_sched #(
  parameter int DEPTH            = 8,
  parameter int CNT_W            = 4,
  parameter int RISCV_ADDR_WIDTH = 32,
  parameter int RISCV_WORD_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] wdata_i,
  input  logic [3:0]                  we_i,
  output logic [RISCV_WORD_WIDTH-1:0] rdata_o,
  output logic                        uart_transmit_o,
  output logic [7:0]                  uart_tx_byte_o,
  input  logic                        uart_is_transmitting_i,
  output logic                        irq_o
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             irq_en;
  state_t           state;
  logic [3:0]       timer;

  logic wr_commit, sel_txq, sel_status, sel_ctrl;
  logic empty, full, busy, push, push_ok, launch;
  logic [RISCV_WORD_WIDTH-1:0] status_word;
  logic [RISCV_WORD_WIDTH-1:0] rd_mux;
  logic unused_bits;

  assign unused_bits = ^{addr_i[RISCV_ADDR_WIDTH-1:4], wdata_i[RISCV_WORD_WIDTH-1:8]};

  // ready_o is the registered echo of valid_i, so a held request commits on its second cycle only
  assign wr_commit  = valid_i && ready_o && (|we_i);
  assign sel_txq    = (addr_i[3:0] == 4'h0);
  assign sel_status = (addr_i[3:0] == 4'h4);
  assign sel_ctrl   = (addr_i[3:0] == 4'h8);

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign busy    = (state != S_IDLE) || uart_is_transmitting_i;
  assign push    = wr_commit && sel_txq;
  assign push_ok = push && !full;
  assign launch  = (state == S_IDLE) && !empty && !uart_is_transmitting_i;

  always_comb begin
    status_word              = '0;
    status_word[0]           = busy;
    status_word[1]           = empty;
    status_word[2]           = full;
    status_word[3]           = overflow;
    status_word[8 +: CNT_W]  = count;
    rd_mux                   = '0;
    if (sel_status) begin
      rd_mux = status_word;
    end else if (sel_ctrl) begin
      rd_mux[0] = irq_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_o  <= 1'b0;
      rdata_o  <= '0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ready_o <= valid_i;
      if (valid_i) begin
        rdata_o <= rd_mux;
      end
      if (wr_commit && sel_ctrl) begin
        irq_en <= wdata_i[0];
      end
      // A push into a full queue is dropped even when a pop frees a slot on the same edge
      if (push && full) begin
        overflow <= 1'b1;
      end else if (wr_commit && sel_ctrl && wdata_i[1]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, launch})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      timer           <= 4'd0;
      uart_transmit_o <= 1'b0;
      uart_tx_byte_o  <= 8'h00;
    end else begin
      uart_transmit_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            state           <= S_LAUNCH;
            uart_tx_byte_o  <= mem[rd_ptr];
            uart_transmit_o <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT_START;
          timer <= 4'd0;
        end
        S_WAIT_START: begin
          // A core that never reports busy loses the byte; no retry is attempted
          if (uart_is_transmitting_i) begin
            state <= S_WAIT_DONE;
          end else if (timer == 4'd15) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!uart_is_transmitting_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en && empty && (state == S_IDLE) && !uart_is_transmitting_i;
    end
  end

endmodule
